// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous memory between the
// CPU instruction-fetch port and the data load/store port.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-low reset
//   if_req/if_addr    fetch request (held until if_gnt)
//   if_gnt            fetch accepted this cycle (combinational)
//   if_rvalid/rdata   fetch data return, one-cycle pulse
//   d_req/we/be/addr/wdata  data request (held until d_gnt)
//   d_gnt             data access accepted this cycle (combinational)
//   d_rvalid/rdata    load data return, one-cycle pulse
//   mem_en/we/be/addr/wdata  memory request, driven in the grant cycle
//   mem_rdata         memory read data, valid MEM_LATENCY cycles after mem_en
module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic                    if_gnt,
  output logic                    if_rvalid,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [DATA_WIDTH/8-1:0] d_be,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  output logic                    d_gnt,
  output logic                    d_rvalid,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  localparam int unsigned BE_W  = DATA_WIDTH / 8;
  localparam int unsigned CNT_W = 3;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_D  = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               owner_q, owner_d;
  logic               last_gnt_q, last_gnt_d;

  logic               issue_c;
  logic               ret_c;
  logic               gnt_if_c;
  logic               gnt_d_c;

  // Issue/return decode and round-robin grant; nothing is granted in reset.
  always_comb begin
    issue_c  = reset && ((state_q == IDLE) || (cnt_q == CNT_W'(1)));
    ret_c    = reset && (state_q == BUSY) && (cnt_q == CNT_W'(1));
    gnt_if_c = issue_c && if_req && (!d_req || (last_gnt_q == PORT_D));
    gnt_d_c  = issue_c && d_req && (!if_req || (last_gnt_q == PORT_IF));
  end

  // Grant, return and memory request outputs; memory bus is zero when idle.
  always_comb begin
    if_gnt    = gnt_if_c;
    d_gnt     = gnt_d_c;
    if_rvalid = ret_c && (owner_q == PORT_IF);
    d_rvalid  = ret_c && (owner_q == PORT_D);
    if_rdata  = mem_rdata;
    d_rdata   = mem_rdata;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt_if_c) begin
      mem_en   = 1'b1;
      mem_be   = {BE_W{1'b1}};
      mem_addr = if_addr;
    end else if (gnt_d_c) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_be    = d_be;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end
  end

  // Next state: count down an outstanding read; a read grant (re)loads it.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    owner_d    = owner_q;
    last_gnt_d = last_gnt_q;
    if (state_q == BUSY) begin
      if (cnt_q == CNT_W'(1)) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
    if (gnt_if_c) begin
      last_gnt_d = PORT_IF;
      owner_d    = PORT_IF;
      state_d    = BUSY;
      cnt_d      = CNT_W'(MEM_LATENCY);
    end else if (gnt_d_c) begin
      last_gnt_d = PORT_D;
      if (!d_we) begin
        owner_d = PORT_D;
        state_d = BUSY;
        cnt_d   = CNT_W'(MEM_LATENCY);
      end
    end
  end

  // State registers; reset drops any outstanding read.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      owner_q    <= PORT_IF;
      last_gnt_q <= PORT_IF;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      last_gnt_q <= last_gnt_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: one instance with MEM_LATENCY=1 (a_*) and one
// with MEM_LATENCY=3 (b_*), sharing request inputs, each with its own memory.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = DW / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [BW-1:0] d_be = '0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;

  logic          a_if_gnt, a_if_rvalid, a_d_gnt, a_d_rvalid, a_mem_en, a_mem_we;
  logic [DW-1:0] a_if_rdata, a_d_rdata, a_mem_wdata, a_mem_rdata;
  logic [BW-1:0] a_mem_be;
  logic [AW-1:0] a_mem_addr;
  logic          b_if_gnt, b_if_rvalid, b_d_gnt, b_d_rvalid, b_mem_en, b_mem_we;
  logic [DW-1:0] b_if_rdata, b_d_rdata, b_mem_wdata, b_mem_rdata;
  logic [BW-1:0] b_mem_be;
  logic [AW-1:0] b_mem_addr;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(a_if_gnt),
    .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(a_d_gnt), .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_be(a_mem_be),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
  );

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(3)) u_dut3 (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(b_if_gnt),
    .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_be(b_mem_be),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
  );

  // Memory models: mode 0 returns addr+0x100, mode 1 returns stored words.
  logic          mem_mode = 1'b0;
  logic [DW-1:0] a_mem [0:63] = '{default: '0};
  logic [DW-1:0] b_mem [0:63] = '{default: '0};
  logic [DW-1:0] a_pipe = '0;
  logic [DW-1:0] b_pipe [0:2] = '{default: '0};

  function automatic logic [DW-1:0] rd_val(input logic [DW-1:0] word, input logic [AW-1:0] addr);
    return mem_mode ? word : (addr + 32'h100);
  endfunction

  always @(posedge clk) begin
    if (a_mem_en && a_mem_we)
      for (int k = 0; k < BW; k++)
        if (a_mem_be[k]) a_mem[a_mem_addr[7:2]][8*k +: 8] <= a_mem_wdata[8*k +: 8];
    a_pipe <= (a_mem_en && !a_mem_we) ? rd_val(a_mem[a_mem_addr[7:2]], a_mem_addr) : '0;
  end
  assign a_mem_rdata = a_pipe;

  always @(posedge clk) begin
    if (b_mem_en && b_mem_we)
      for (int k = 0; k < BW; k++)
        if (b_mem_be[k]) b_mem[b_mem_addr[7:2]][8*k +: 8] <= b_mem_wdata[8*k +: 8];
    b_pipe[0] <= (b_mem_en && !b_mem_we) ? rd_val(b_mem[b_mem_addr[7:2]], b_mem_addr) : '0;
    b_pipe[1] <= b_pipe[0];
    b_pipe[2] <= b_pipe[1];
  end
  assign b_mem_rdata = b_pipe[2];

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] q_if[$];
  logic [DW-1:0] q_d[$];

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    q_if.delete(); q_d.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    reset = 1'b0; if_req = 1'b1; if_addr = 32'h4; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if ({a_if_gnt, a_d_gnt, a_if_rvalid, a_d_rvalid, a_mem_en, a_mem_we} !== 6'b0) begin
        errors++; $display("FAIL reset_a cyc%0d: got %b expected 000000", c,
          {a_if_gnt, a_d_gnt, a_if_rvalid, a_d_rvalid, a_mem_en, a_mem_we});
      end
      checks++;
      if ({b_if_gnt, b_d_gnt, b_if_rvalid, b_d_rvalid, b_mem_en, b_mem_we} !== 6'b0) begin
        errors++; $display("FAIL reset_b cyc%0d: got %b expected 000000", c,
          {b_if_gnt, b_d_gnt, b_if_rvalid, b_d_rvalid, b_mem_en, b_mem_we});
      end
    end
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({a_d_gnt, a_if_gnt} !== 2'b10 || a_mem_addr !== 32'h8) begin
      errors++; $display("FAIL first_conflict_a: got d/if=%b addr=%h expected 10 addr=00000008",
        {a_d_gnt, a_if_gnt}, a_mem_addr);
    end
    checks++;
    if ({b_d_gnt, b_if_gnt} !== 2'b10) begin
      errors++; $display("FAIL first_conflict_b: got d/if=%b expected 10", {b_d_gnt, b_if_gnt});
    end
  endtask

  task automatic test_fetch_stream();
    logic exp_g, exp_rv;
    logic [DW-1:0] e;
    mem_mode = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if_req = (c < 3); if_addr = AW'(4 * c);
      @(negedge clk);
      exp_g = (c < 3); exp_rv = (c >= 1 && c <= 3);
      checks++;
      if (a_if_rvalid !== exp_rv) begin
        errors++; $display("FAIL fetch_rvalid cyc%0d: got %b expected %b", c, a_if_rvalid, exp_rv);
      end
      if (a_if_rvalid) begin
        checks++;
        if (q_if.size() == 0) begin
          errors++; $display("FAIL fetch_sb cyc%0d: got rvalid expected none queued", c);
        end else begin
          e = q_if.pop_front();
          if (a_if_rdata !== e) begin
            errors++; $display("FAIL fetch_data cyc%0d: got %h expected %h", c, a_if_rdata, e);
          end
        end
      end
      checks++;
      if (a_if_gnt !== exp_g) begin
        errors++; $display("FAIL fetch_gnt cyc%0d: got %b expected %b", c, a_if_gnt, exp_g);
      end
      if (a_if_gnt) begin
        checks++;
        if (a_mem_addr !== AW'(4 * c) || a_mem_we !== 1'b0 || a_mem_be !== 4'hF) begin
          errors++; $display("FAIL fetch_mem cyc%0d: got addr=%h we=%b be=%h expected addr=%h we=0 be=f",
            c, a_mem_addr, a_mem_we, a_mem_be, AW'(4 * c));
        end
        q_if.push_back(AW'(4 * c) + 32'h100);
      end
    end
    checks++;
    if (q_if.size() != 0) begin
      errors++; $display("FAIL fetch_drain: got %0d pending expected 0", q_if.size());
    end
  endtask

  task automatic test_dual_rr();
    logic rr_last, win, prev_w;
    logic [DW-1:0] e;
    mem_mode = 1'b0; rr_last = 1'b0; prev_w = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if_req = (c < 6); if_addr = 32'h40;
      d_req = (c < 6); d_we = 1'b0; d_addr = 32'h80;
      @(negedge clk);
      if (c >= 1 && c <= 6) begin
        checks++;
        if ({a_d_rvalid, a_if_rvalid} !== {prev_w, ~prev_w}) begin
          errors++; $display("FAIL rr_rvalid cyc%0d: got d/if=%b expected %b", c,
            {a_d_rvalid, a_if_rvalid}, {prev_w, ~prev_w});
        end
      end
      if (a_d_rvalid) begin
        checks++;
        e = (q_d.size() != 0) ? q_d.pop_front() : 32'hXXXX_XXXX;
        if (a_d_rdata !== e) begin
          errors++; $display("FAIL rr_d_data cyc%0d: got %h expected %h", c, a_d_rdata, e);
        end
      end
      if (a_if_rvalid) begin
        checks++;
        e = (q_if.size() != 0) ? q_if.pop_front() : 32'hXXXX_XXXX;
        if (a_if_rdata !== e) begin
          errors++; $display("FAIL rr_if_data cyc%0d: got %h expected %h", c, a_if_rdata, e);
        end
      end
      if (c < 6) begin
        win = ~rr_last; rr_last = win;
        checks++;
        if ({a_d_gnt, a_if_gnt} !== {win, ~win} || a_mem_addr !== (win ? 32'h80 : 32'h40)) begin
          errors++; $display("FAIL rr_gnt cyc%0d: got d/if=%b addr=%h expected %b addr=%h", c,
            {a_d_gnt, a_if_gnt}, a_mem_addr, {win, ~win}, (win ? 32'h80 : 32'h40));
        end
        if (win) q_d.push_back(32'h180); else q_if.push_back(32'h140);
        prev_w = win;
      end
    end
    checks++;
    if (q_d.size() + q_if.size() != 0) begin
      errors++; $display("FAIL rr_drain: got %0d pending expected 0", q_d.size() + q_if.size());
    end
  endtask

  task automatic test_write_read();
    logic [DW-1:0] e;
    mem_mode = 1'b1;
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h20; d_wdata = 32'hDEADBEEF;
    @(negedge clk);
    checks++;
    if (a_d_gnt !== 1'b1 || a_mem_we !== 1'b1 || a_mem_be !== 4'b0011 || a_mem_wdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL write_issue: got gnt=%b we=%b be=%b wdata=%h expected 1 1 0011 deadbeef",
        a_d_gnt, a_mem_we, a_mem_be, a_mem_wdata);
    end
    @(posedge clk); #1;
    d_we = 1'b0;
    @(negedge clk);
    checks++;
    if (a_d_rvalid !== 1'b0 || a_d_gnt !== 1'b1 || a_mem_we !== 1'b0) begin
      errors++; $display("FAIL read_after_write: got rvalid=%b gnt=%b we=%b expected 0 1 0",
        a_d_rvalid, a_d_gnt, a_mem_we);
    end
    if (a_d_gnt) q_d.push_back(32'h0000BEEF);
    @(posedge clk); #1;
    d_req = 1'b0;
    @(negedge clk);
    checks++;
    if (a_d_rvalid !== 1'b1 || q_d.size() == 0) begin
      errors++; $display("FAIL read_rvalid: got %b expected 1", a_d_rvalid);
    end else begin
      e = q_d.pop_front();
      checks++;
      if (a_d_rdata !== e) begin
        errors++; $display("FAIL read_data: got %h expected %h", a_d_rdata, e);
      end
    end
    mem_mode = 1'b0;
  endtask

  // Fetch then load on the latency-3 instance; the load waits for the return.
  task automatic test_latency3();
    localparam logic [7:0] EXP_IFG = 8'b0000_0001;
    localparam logic [7:0] EXP_DG  = 8'b0000_1000;
    localparam logic [7:0] EXP_IFV = 8'b0000_1000;
    localparam logic [7:0] EXP_DV  = 8'b0100_0000;
    logic [DW-1:0] e;
    mem_mode = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if_req = (c == 0); if_addr = 32'h10;
      d_req = (c >= 1 && c <= 3); d_we = 1'b0; d_addr = 32'h30;
      @(negedge clk);
      checks++;
      if ({b_if_gnt, b_d_gnt, b_if_rvalid, b_d_rvalid} !== {EXP_IFG[c], EXP_DG[c], EXP_IFV[c], EXP_DV[c]}) begin
        errors++; $display("FAIL lat3 cyc%0d: got ifg/dg/ifv/dv=%b expected %b", c,
          {b_if_gnt, b_d_gnt, b_if_rvalid, b_d_rvalid}, {EXP_IFG[c], EXP_DG[c], EXP_IFV[c], EXP_DV[c]});
      end
      if (b_if_rvalid) begin
        checks++;
        e = (q_if.size() != 0) ? q_if.pop_front() : 32'hXXXX_XXXX;
        if (b_if_rdata !== e) begin
          errors++; $display("FAIL lat3_if_data cyc%0d: got %h expected %h", c, b_if_rdata, e);
        end
      end
      if (b_d_rvalid) begin
        checks++;
        e = (q_d.size() != 0) ? q_d.pop_front() : 32'hXXXX_XXXX;
        if (b_d_rdata !== e) begin
          errors++; $display("FAIL lat3_d_data cyc%0d: got %h expected %h", c, b_d_rdata, e);
        end
      end
      if (b_if_gnt) q_if.push_back(32'h110);
      if (b_d_gnt) q_d.push_back(32'h130);
    end
  endtask

  // Reset one cycle after a latency-3 read grant drops that read.
  task automatic test_reset_abort();
    localparam logic [9:0] EXP_DG  = 10'b00_0000_0001;
    localparam logic [9:0] EXP_IFG = 10'b00_0100_0000;
    localparam logic [9:0] EXP_IFV = 10'b10_0000_0000;
    logic [DW-1:0] e;
    mem_mode = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      d_req = (c == 0); d_we = 1'b0; d_addr = 32'h50;
      if_req = (c == 6); if_addr = 32'h60;
      reset = (c != 1);
      if (c == 1) begin
        q_d.delete(); q_if.delete();
      end
      @(negedge clk);
      checks++;
      if ({b_d_gnt, b_if_gnt, b_d_rvalid, b_if_rvalid} !== {EXP_DG[c], EXP_IFG[c], 1'b0, EXP_IFV[c]}) begin
        errors++; $display("FAIL abort cyc%0d: got dg/ifg/dv/ifv=%b expected %b", c,
          {b_d_gnt, b_if_gnt, b_d_rvalid, b_if_rvalid}, {EXP_DG[c], EXP_IFG[c], 1'b0, EXP_IFV[c]});
      end
      if (b_if_rvalid) begin
        checks++;
        e = (q_if.size() != 0) ? q_if.pop_front() : 32'hXXXX_XXXX;
        if (b_if_rdata !== e) begin
          errors++; $display("FAIL abort_if_data cyc%0d: got %h expected %h", c, b_if_rdata, e);
        end
      end
      if (b_d_gnt) q_d.push_back(32'h150);
      if (b_if_gnt) q_if.push_back(32'h160);
    end
    checks++;
    if (q_if.size() != 0) begin
      errors++; $display("FAIL abort_drain: got %0d pending expected 0", q_if.size());
    end
  endtask

  initial begin
    test_reset();
    do_reset();
    test_fetch_stream();
    do_reset();
    test_dual_rr();
    do_reset();
    test_write_read();
    do_reset();
    test_latency3();
    do_reset();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
